// File: rtl/wishbone_master_engine_if.sv
// Command and Wishbone signal bundle for wishbone_master_engine.
// The master modport is the engine's view; slave is the command poster / bus model view.
interface wishbone_master_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [SEL_WIDTH-1:0]  select;
  logic [1:0]            op_code;
  logic                  do_work;
  logic [DATA_WIDTH-1:0] data_outr;
  logic                  work_doner;
  logic                  error_r;

  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    input  address, data_in, select, op_code, do_work,
    output data_outr, work_doner, error_r,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output address, data_in, select, op_code, do_work,
    input  data_outr, work_doner, error_r,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wishbone_master_engine.sv
// Single-command Wishbone classic master: one command in, one bus cycle out, four-phase completion.
// Optional WISHBONE_MASTER_TIMEOUT_EN aborts a bus cycle after TIMEOUT_CYCLES strobe cycles.
module wishbone_master_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  wishbone_master_engine_if.master bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  cyc_q, cyc_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

`ifdef WISHBONE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Handshake: do_work and work_doner form a four-phase pair. A command is taken
  // when do_work is high in IDLE; work_doner rises on completion and stays high
  // until do_work is seen low, so each command needs a fresh rising do_work.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    dout_d  = dout_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.do_work) begin
          adr_d = bus.address;
          dat_d = bus.data_in;
          sel_d = bus.select;
          we_d  = (bus.op_code == OP_WRITE);
          err_d = 1'b0;
          if (bus.op_code == OP_READ || bus.op_code == OP_WRITE) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = (bus.op_code != OP_NOP);
          end
        end
      end
      ST_BUS: begin
        // ERR beats ACK when both arrive on the same edge.
        if (bus.wb_err_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (bus.wb_ack_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            dout_d = bus.wb_dat_i;
          end
        end
`ifdef WISHBONE_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (!we_q) begin
            dout_d = '1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (!bus.do_work) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = cyc_q;
  assign bus.data_outr  = dout_q;
  assign bus.work_doner = done_q;
  assign bus.error_r    = err_q;
  assign state_dbg      = state_q;

endmodule
